// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N producers.
// A grant lasts until a last marker, MAX_BURST accepted words, or a request drop.
module fifo_wr_arbiter #(
  parameter int N         = 4,
  parameter int ID_W      = 2,
  parameter int B         = 8,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req,
  input  logic [N-1:0]      last,
  input  logic [N*B-1:0]    data,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      ack,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [B-1:0]      fifo_w_data,
  output logic              busy,
  output logic [ID_W-1:0]   owner
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [CNT_W-1:0] beat_cnt;
  logic [B-1:0]    words [N];
  logic            pick_found;
  logic [ID_W-1:0] pick_idx;
  logic [ID_W-1:0] cand;
  logic [ID_W-1:0] next_ptr;
  logic            own_req;
  logic            own_last;
  logic            release_now;

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = data[i*B +: B];
  end

  assign own_req     = req[owner];
  assign own_last    = last[owner];
  assign fifo_wr     = (state == GRANT) & own_req & ~fifo_full;
  assign ack         = gnt & {N{fifo_wr}};
  assign fifo_w_data = words[owner];

  // A stalled word never counts toward last or the burst cap; only a drop releases during a stall.
  assign release_now = ~own_req |
                       (fifo_wr & (own_last | (beat_cnt == CNT_W'(MAX_BURST - 1))));

  assign next_ptr = (owner == ID_W'(N - 1)) ? '0 : owner + 1'b1;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = ID_W'((32'(rr_ptr) + k) % N);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      gnt      <= '0;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_found) begin
            state    <= GRANT;
            busy     <= 1'b1;
            gnt      <= N'(1) << pick_idx;
            owner    <= pick_idx;
            beat_cnt <= '0;
          end
        end
        GRANT: begin
          if (fifo_wr) beat_cnt <= beat_cnt + 1'b1;
          if (release_now) begin
            state  <= IDLE;
            busy   <= 1'b0;
            gnt    <= '0;
            rr_ptr <= next_ptr;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus a random phase,
// all checked cycle by cycle against a behavioural model and a per-requester word scoreboard.
module tb_fifo_wr_arbiter;
  localparam int N = 4, ID_W = 2, B = 8, MB = 4, CNT_W = 5;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req, last, gnt, ack;
  logic [N*B-1:0] data;
  logic fifo_full, fifo_wr, busy;
  logic [B-1:0] fifo_w_data;
  logic [ID_W-1:0] owner;

  fifo_wr_arbiter #(.N(N), .ID_W(ID_W), .B(B), .MAX_BURST(MB), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .req(req), .last(last), .data(data),
    .gnt(gnt), .ack(ack), .fifo_full(fifo_full), .fifo_wr(fifo_wr),
    .fifo_w_data(fifo_w_data), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  logic [B:0] q [N][$];     // per-requester pending words: {last, data}
  logic [N-1:0] drop;
  int acc [N];
  int drop_after [N];
  bit full_q [$];
  bit rnd_full;
  bit m_busy;
  int m_owner, m_ptr, m_cnt;
  int grants [$];
  int n_writes;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] expv);
    n_chk++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push(int i, logic [B-1:0] d, bit l);
    q[i].push_back({l, d});
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (q[i].size() > 0 && !drop[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      q[i].delete();
      acc[i] = 0;
      drop_after[i] = -1;
    end
    drop = '0; full_q.delete(); rnd_full = 0;
    req = '0; last = '0; fifo_full = 1'b0;
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    clear_stim();
    #1;
    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_wr", fifo_wr, 0);
    chk("rst_ack", ack, 0);
    @(negedge clk);
    reset = 1'b0;
    grants.delete();
    n_writes = 0;
  endtask

  // One clock: drive at the falling edge, check, then advance the model across the next rising edge.
  task automatic cycle();
    logic [N-1:0] e_gnt, e_ack;
    logic [B:0] w;
    bit e_wr, rel, found;
    int sel;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      req[i] = (q[i].size() > 0) && !drop[i];
      if (q[i].size() > 0) {last[i], data[i*B +: B]} = q[i][0];
      else begin
        last[i] = 1'($urandom);
        data[i*B +: B] = B'($urandom);
      end
    end
    if (full_q.size() > 0) fifo_full = full_q.pop_front();
    else fifo_full = rnd_full ? ($urandom_range(3) == 0) : 1'b0;
    #1;
    e_wr  = m_busy && req[m_owner] && !fifo_full;
    e_gnt = '0;
    if (m_busy) e_gnt[m_owner] = 1'b1;
    e_ack = e_wr ? e_gnt : '0;
    chk("gnt", gnt, e_gnt);
    chk("ack", ack, e_ack);
    chk("fifo_wr", fifo_wr, e_wr);
    chk("busy", busy, m_busy);
    chk("owner", owner, m_owner);
    if (m_busy) chk("w_data", fifo_w_data, data[m_owner*B +: B]);
    if (e_wr) begin
      w = q[m_owner].pop_front();
      chk("fifo_word", fifo_w_data, w[B-1:0]);
      n_writes++;
      acc[m_owner]++;
      if (acc[m_owner] == drop_after[m_owner]) drop[m_owner] = 1'b1;
    end
    if (!m_busy) begin
      found = 0; sel = 0;
      for (int k = 0; k < N; k++)
        if (!found && req[(m_ptr + k) % N]) begin
          found = 1; sel = (m_ptr + k) % N;
        end
      if (found) begin
        m_busy = 1; m_owner = sel; m_cnt = 0;
        grants.push_back(sel);
      end
    end else begin
      rel = !req[m_owner] || (e_wr && (last[m_owner] || m_cnt == MB - 1));
      if (e_wr) m_cnt++;
      if (rel) begin
        m_busy = 0;
        m_ptr = (m_owner + 1) % N;
      end
    end
  endtask

  task automatic run_until_idle(int budget);
    int c = 0;
    while ((pending() || m_busy) && c < budget) begin
      cycle();
      c++;
    end
    chk("drain_bound", (c < budget) ? 1 : 0, 1);
  endtask

  task automatic chk_grants(string tag, int n, int a0 = 0, int a1 = 0, int a2 = 0, int a3 = 0, int a4 = 0);
    int e [5];
    e = '{a0, a1, a2, a3, a4};
    chk({tag, "_count"}, grants.size(), n);
    for (int i = 0; i < n && i < grants.size(); i++) chk({tag, "_order"}, grants[i], e[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; data = '0;
    clear_stim();

    // 1: single burst terminated by last, then scan resumes after owner 2
    do_reset();
    push(2, 8'hA1, 0); push(2, 8'hA2, 0); push(2, 8'hA3, 1);
    cycle();
    cycle();
    chk("t1_gnt", gnt, 4'b0100);
    run_until_idle(50);
    chk_grants("t1", 1, 2);
    chk("t1_writes", n_writes, 3);
    chk("t1_owner", owner, 2);
    push(0, 8'h10, 1); push(3, 8'h30, 1);
    run_until_idle(50);
    chk_grants("t1_next", 3, 2, 3, 0);

    // 2: all requesting, single-word bursts rotate
    do_reset();
    push(0, 8'h01, 1); push(0, 8'h02, 1);
    push(1, 8'h11, 1); push(2, 8'h21, 1); push(3, 8'h31, 1);
    run_until_idle(60);
    chk_grants("t2", 5, 0, 1, 2, 3, 0);
    chk("t2_writes", n_writes, 5);

    // 3: burst cap forces release to a waiting requester
    do_reset();
    for (int k = 0; k < 10; k++) push(1, B'(8'h40 + k), 0);
    push(3, 8'h71, 0); push(3, 8'h72, 1);
    run_until_idle(100);
    chk_grants("t3", 4, 1, 3, 1, 1);
    chk("t3_writes", n_writes, 12);

    // 4: three-cycle full stall mid-burst
    do_reset();
    for (int k = 0; k < 5; k++) push(2, B'(8'h50 + k), k == 4);
    full_q.push_back(0); full_q.push_back(0);
    full_q.push_back(1); full_q.push_back(1); full_q.push_back(1);
    run_until_idle(60);
    chk_grants("t4", 2, 2, 2);
    chk("t4_writes", n_writes, 5);

    // 5: owner drops request after two words
    do_reset();
    for (int k = 0; k < 5; k++) push(0, B'(8'h60 + k), 0);
    push(2, 8'h6F, 1);
    drop_after[0] = 2;
    run_until_idle(60);
    chk_grants("t5", 2, 0, 2);
    chk("t5_writes", n_writes, 3);

    // 6: asynchronous reset between edges during a burst
    do_reset();
    for (int k = 0; k < 4; k++) push(2, B'(8'h80 + k), 0);
    cycle();
    cycle();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_gnt", gnt, 0);
    chk("t6_wr", fifo_wr, 0);
    chk("t6_ack", ack, 0);
    chk("t6_busy", busy, 0);
    clear_stim();
    @(negedge clk);
    reset = 1'b0;
    grants.delete(); n_writes = 0;
    push(1, 8'h91, 1); push(3, 8'h93, 1);
    run_until_idle(50);
    chk_grants("t6", 2, 1, 3);

    // random traffic with full stalls and request drops
    do_reset();
    rnd_full = 1;
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++) begin
        if (q[i].size() < 6 && $urandom_range(3) == 0)
          push(i, B'($urandom), $urandom_range(3) == 0);
        if ($urandom_range(15) == 0) drop[i] = ~drop[i];
      end
      cycle();
    end
    drop = '0;
    rnd_full = 0;
    run_until_idle(400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
